// File: rtl/af_rr_if_arbiter.sv
// af_rr_if_arbiter: round-robin owner of a shared valid/data/ready bus, with burst hold and release.
// Optional forced-release hold limit enabled by defining AF_ARB_HOLD_LIMIT_EN.
`default_nettype none

module af_rr_if_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int DATA_W   = 8,
   parameter int MAX_HOLD = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_REQ-1:0]          req,
   input  logic [NUM_REQ-1:0]          req_last,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   input  logic                        bus_ready,
   output logic                        bus_valid,
   output logic [DATA_W-1:0]           bus_data,
   output logic [NUM_REQ-1:0]          gnt,
   output logic [$clog2(NUM_REQ)-1:0]  gnt_id,
   output logic                        busy
`ifdef AF_ARB_HOLD_LIMIT_EN
   ,
   output logic                        hold_tmo
`endif
);

   localparam int         IW   = $clog2(NUM_REQ);
   localparam logic [IW:0] NREQ = (IW+1)'(NUM_REQ);

   if ((NUM_REQ < 2) || (NUM_REQ > 16) || (DATA_W < 1) || (MAX_HOLD < 2)) begin : g_param_check
      $error("af_rr_if_arbiter: illegal parameter set");
   end

   typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

   state_t               state_q, state_d;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic [IW-1:0]        gnt_id_q, gnt_id_d;
   logic [IW-1:0]        rr_ptr_q, rr_ptr_d;

   logic                 w_found;
   logic [IW-1:0]        w_pick_id;
   logic [IW:0]          w_sum;
   logic [IW:0]          w_next_ptr;
   logic                 w_owner_req;
   logic                 w_owner_last;
   logic                 w_rel_ab;
   logic                 w_force;

   // First requester at or after rr_ptr, wrapping at NUM_REQ.
   always_comb begin
      w_found   = 1'b0;
      w_pick_id = '0;
      w_sum     = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         w_sum = {1'b0, rr_ptr_q} + (IW+1)'(j);
         if (w_sum >= NREQ) begin
            w_sum = w_sum - NREQ;
         end
         if (!w_found && req[w_sum[IW-1:0]]) begin
            w_found   = 1'b1;
            w_pick_id = w_sum[IW-1:0];
         end
      end
   end

   always_comb begin
      w_next_ptr = {1'b0, gnt_id_q} + (IW+1)'(1);
      if (w_next_ptr == NREQ) begin
         w_next_ptr = '0;
      end
   end

   assign w_owner_req  = req[gnt_id_q];
   assign w_owner_last = req_last[gnt_id_q];
   assign bus_valid    = (state_q == S_GRANT) && w_owner_req;
   assign bus_data     = bus_valid ? req_data[gnt_id_q*DATA_W +: DATA_W] : '0;
   // Release by final beat accepted, or by owner dropping its request.
   assign w_rel_ab     = (state_q == S_GRANT) &&
                         ((bus_valid && bus_ready && w_owner_last) || !w_owner_req);

`ifdef AF_ARB_HOLD_LIMIT_EN
   localparam int HW = $clog2(MAX_HOLD + 1);

   logic [HW-1:0] hold_cnt_q, hold_cnt_d;
   logic          hold_tmo_q, hold_tmo_d;

   assign w_force = (state_q == S_GRANT) && (hold_cnt_q == HW'(MAX_HOLD)) && !w_rel_ab;

   always_comb begin
      hold_cnt_d = '0;
      hold_tmo_d = 1'b0;
      if (state_q == S_IDLE) begin
         if (w_found) begin
            hold_cnt_d = HW'(1);
         end
      end else if (w_rel_ab || w_force) begin
         hold_tmo_d = w_force;
      end else begin
         hold_cnt_d = hold_cnt_q + HW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_cnt_q <= '0;
         hold_tmo_q <= 1'b0;
      end else begin
         hold_cnt_q <= hold_cnt_d;
         hold_tmo_q <= hold_tmo_d;
      end
   end

   assign hold_tmo = hold_tmo_q;
`else
   assign w_force = 1'b0;
`endif

   always_comb begin
      state_d  = state_q;
      gnt_d    = gnt_q;
      gnt_id_d = gnt_id_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
         S_IDLE: begin
            if (w_found) begin
               state_d            = S_GRANT;
               gnt_d              = '0;
               gnt_d[w_pick_id]   = 1'b1;
               gnt_id_d           = w_pick_id;
            end
         end
         S_GRANT: begin
            // gnt_id deliberately holds through the gap cycle.
            if (w_rel_ab || w_force) begin
               state_d  = S_IDLE;
               gnt_d    = '0;
               rr_ptr_d = w_next_ptr[IW-1:0];
            end
         end
         default: begin
            state_d = S_IDLE;
            gnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         gnt_q    <= '0;
         gnt_id_q <= '0;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         gnt_q    <= gnt_d;
         gnt_id_q <= gnt_id_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign gnt    = gnt_q;
   assign gnt_id = gnt_id_q;
   assign busy   = (state_q == S_GRANT);

endmodule

`default_nettype wire

// File: tb/tb_af_rr_if_arbiter.sv
// tb_af_rr_if_arbiter: directed vector table plus hand sequences for stall, hold limit and mid-burst reset.
`default_nettype none

module tb_af_rr_if_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [3:0]  req_last;
   logic [31:0] req_data;
   logic        bus_ready;
   logic        bus_valid;
   logic [7:0]  bus_data;
   logic [3:0]  gnt;
   logic [1:0]  gnt_id;
   logic        busy;
`ifdef AF_ARB_HOLD_LIMIT_EN
   logic        hold_tmo;
`endif

   int n_err;
   int n_checks;

   af_rr_if_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_HOLD(16)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .req_last  (req_last),
      .req_data  (req_data),
      .bus_ready (bus_ready),
      .bus_valid (bus_valid),
      .bus_data  (bus_data),
      .gnt       (gnt),
      .gnt_id    (gnt_id),
      .busy      (busy)
`ifdef AF_ARB_HOLD_LIMIT_EN
      ,
      .hold_tmo  (hold_tmo)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst_n;
      logic [3:0] req;
      logic [3:0] last;
      logic       rdy;
      logic [3:0] e_gnt;
      logic [1:0] e_id;
      logic       e_busy;
      logic       e_valid;
      logic [7:0] e_data;
   } vec_t;

   vec_t tbl [19];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic check_all(input string nm, input logic [3:0] e_gnt, input logic [1:0] e_id,
                            input logic e_busy, input logic e_valid, input logic [7:0] e_data);
      check({nm, " gnt"},   32'(gnt),       32'(e_gnt));
      check({nm, " id"},    32'(gnt_id),    32'(e_id));
      check({nm, " busy"},  32'(busy),      32'(e_busy));
      check({nm, " valid"}, 32'(bus_valid), 32'(e_valid));
      check({nm, " data"},  32'(bus_data),  32'(e_data));
   endtask

   initial begin
      n_err     = 0;
      n_checks  = 0;
      rst_n     = 1'b0;
      req       = 4'hF;
      req_last  = 4'hF;
      bus_ready = 1'b1;
      req_data  = {8'hD3, 8'hC2, 8'hB1, 8'hA0};

      //          rst   req   last  rdy   gnt   id    busy  vld   data
      tbl[0]  = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h0, 2'd0, 1'b0, 1'b0, 8'h00};
      tbl[1]  = '{1'b0, 4'hF, 4'hF, 1'b1, 4'h0, 2'd0, 1'b0, 1'b0, 8'h00};
      tbl[2]  = '{1'b1, 4'hF, 4'hF, 1'b1, 4'h0, 2'd0, 1'b0, 1'b0, 8'h00};
      tbl[3]  = '{1'b1, 4'hF, 4'hF, 1'b1, 4'h1, 2'd0, 1'b1, 1'b1, 8'hA0};
      tbl[4]  = '{1'b1, 4'hF, 4'hF, 1'b1, 4'h0, 2'd0, 1'b0, 1'b0, 8'h00};
      tbl[5]  = '{1'b1, 4'hF, 4'hF, 1'b1, 4'h2, 2'd1, 1'b1, 1'b1, 8'hB1};
      tbl[6]  = '{1'b1, 4'hF, 4'hF, 1'b1, 4'h0, 2'd1, 1'b0, 1'b0, 8'h00};
      tbl[7]  = '{1'b1, 4'hF, 4'hF, 1'b1, 4'h4, 2'd2, 1'b1, 1'b1, 8'hC2};
      tbl[8]  = '{1'b1, 4'hF, 4'hF, 1'b1, 4'h0, 2'd2, 1'b0, 1'b0, 8'h00};
      tbl[9]  = '{1'b1, 4'hF, 4'hF, 1'b1, 4'h8, 2'd3, 1'b1, 1'b1, 8'hD3};
      tbl[10] = '{1'b1, 4'hF, 4'hF, 1'b1, 4'h0, 2'd3, 1'b0, 1'b0, 8'h00};
      tbl[11] = '{1'b1, 4'hF, 4'hF, 1'b1, 4'h1, 2'd0, 1'b1, 1'b1, 8'hA0};
      tbl[12] = '{1'b1, 4'hF, 4'h0, 1'b1, 4'h0, 2'd0, 1'b0, 1'b0, 8'h00};
      tbl[13] = '{1'b1, 4'hF, 4'h0, 1'b1, 4'h2, 2'd1, 1'b1, 1'b1, 8'hB1};
      tbl[14] = '{1'b1, 4'hD, 4'h0, 1'b1, 4'h2, 2'd1, 1'b1, 1'b0, 8'h00};
      tbl[15] = '{1'b1, 4'hD, 4'h0, 1'b1, 4'h0, 2'd1, 1'b0, 1'b0, 8'h00};
      tbl[16] = '{1'b1, 4'hD, 4'h4, 1'b1, 4'h4, 2'd2, 1'b1, 1'b1, 8'hC2};
      tbl[17] = '{1'b1, 4'h0, 4'h0, 1'b1, 4'h0, 2'd2, 1'b0, 1'b0, 8'h00};
      tbl[18] = '{1'b1, 4'h0, 4'h0, 1'b1, 4'h0, 2'd2, 1'b0, 1'b0, 8'h00};

      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         rst_n     = tbl[i].rst_n;
         req       = tbl[i].req;
         req_last  = tbl[i].last;
         bus_ready = tbl[i].rdy;
         #2;
         check_all($sformatf("row%0d", i), tbl[i].e_gnt, tbl[i].e_id,
                   tbl[i].e_busy, tbl[i].e_valid, tbl[i].e_data);
`ifdef AF_ARB_HOLD_LIMIT_EN
         check($sformatf("row%0d hold_tmo", i), 32'(hold_tmo), 32'd0);
`endif
      end

      // Stall: owner 2 with final beat pending while bus not ready.
      req_data[23:16] = 8'hA5;
      @(negedge clk);
      req = 4'b0100; req_last = 4'b0100; bus_ready = 1'b0;
      #2;
      check_all("stall pre", 4'h0, 2'd2, 1'b0, 1'b0, 8'h00);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         #2;
         check_all($sformatf("stall c%0d", c), 4'h4, 2'd2, 1'b1, 1'b1, 8'hA5);
      end
      @(negedge clk);
      bus_ready = 1'b1;
      #2;
      check_all("stall go", 4'h4, 2'd2, 1'b1, 1'b1, 8'hA5);
      @(negedge clk);
      req = 4'b0000; req_last = 4'b0000;
      #2;
      check_all("stall rel", 4'h0, 2'd2, 1'b0, 1'b0, 8'h00);

      // Hold: owner 0 never signals its last beat.
      @(negedge clk);
      req = 4'b0001;
      #2;
      check("hold pre gnt", 32'(gnt), 32'h0);
      for (int c = 1; c <= 16; c++) begin
         @(negedge clk);
         #2;
         check($sformatf("hold c%0d gnt", c), 32'(gnt), 32'h1);
`ifdef AF_ARB_HOLD_LIMIT_EN
         check($sformatf("hold c%0d tmo", c), 32'(hold_tmo), 32'h0);
`endif
      end
`ifdef AF_ARB_HOLD_LIMIT_EN
      @(negedge clk);
      #2;
      check("hold forced gnt", 32'(gnt), 32'h0);
      check("hold forced busy", 32'(busy), 32'h0);
      check("hold forced tmo", 32'(hold_tmo), 32'h1);
      @(negedge clk);
      #2;
      check("hold regrant gnt", 32'(gnt), 32'h1);
      check("hold regrant tmo", 32'(hold_tmo), 32'h0);
`else
      for (int c = 17; c <= 40; c++) begin
         @(negedge clk);
         #2;
         check($sformatf("hold c%0d gnt", c), 32'(gnt), 32'h1);
      end
`endif
      @(negedge clk);
      req = 4'b0000;
      #2;
      check_all("hold drop", 4'h1, 2'd0, 1'b1, 1'b0, 8'h00);
      @(negedge clk);
      #2;
      check_all("hold idle", 4'h0, 2'd0, 1'b0, 1'b0, 8'h00);

      // Reset in the middle of owner 3's burst.
      @(negedge clk);
      req = 4'b1000;
      #2;
      check("rst pre gnt", 32'(gnt), 32'h0);
      @(negedge clk);
      #2;
      check_all("rst owner3", 4'h8, 2'd3, 1'b1, 1'b1, 8'hD3);
      #1;
      rst_n = 1'b0;
      #1;
      check_all("rst async", 4'h0, 2'd0, 1'b0, 1'b0, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      #2;
      check("rst rel gnt", 32'(gnt), 32'h0);
      @(negedge clk);
      #2;
      check_all("rst regrant", 4'h8, 2'd3, 1'b1, 1'b1, 8'hD3);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
